// File: rtl/game_state_ctrl.sv
// Top-level game flow controller: tracks play/pause/respawn/level-clear/game-over,
// counts lives and levels, and drives the reset/enable lines for the rest of the game.
module game_state_ctrl #(
   parameter int NUM_GHOSTS    = 2,
   parameter int X_W           = 6,
   parameter int Y_W           = 5,
   parameter int START_LIVES   = 3,
   parameter int RESUME_CYCLES = 250000000,
   parameter int PILL_W        = 9,
   parameter int TOTAL_PILLS   = 300,
   parameter int MAX_LEVEL     = 4,
   localparam int LEVEL_W      = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1
) (
   input  logic                      CLOCK_50,
   input  logic                      reset_n,
   input  logic                      start,
   input  logic                      pause,
   input  logic [X_W-1:0]            pacman_x,
   input  logic [Y_W-1:0]            pacman_y,
   input  logic [NUM_GHOSTS*X_W-1:0] ghost_x,
   input  logic [NUM_GHOSTS*Y_W-1:0] ghost_y,
   input  logic [PILL_W-1:0]         pill_count,
   output logic [2:0]                state,
   output logic [2:0]                lives,
   output logic [LEVEL_W-1:0]        level,
   output logic                      sprite_reset,
   output logic                      map_wr_reset,
   output logic                      display_reset,
   output logic                      ghost_enable,
   output logic                      life_lost
);

   localparam int CNT_W = $clog2(RESUME_CYCLES + 1);
   localparam logic [CNT_W-1:0]   RESUME_LOAD = CNT_W'(RESUME_CYCLES - 1);
   localparam logic [PILL_W-1:0]  PILL_TARGET = PILL_W'(TOTAL_PILLS);
   localparam logic [LEVEL_W-1:0] LAST_LEVEL  = LEVEL_W'(MAX_LEVEL - 1);
   localparam logic [2:0]         INIT_LIVES  = 3'(START_LIVES);

   typedef enum logic [2:0] {
      ST_INIT   = 3'd0,
      ST_PLAY   = 3'd1,
      ST_PAUSE  = 3'd2,
      ST_RESUME = 3'd3,
      ST_CLEAR  = 3'd4,
      ST_OVER   = 3'd5
   } state_t;

   state_t           cur_state;
   state_t           nxt_state;
   logic             hit;
   logic             hit_q;
   logic             pause_q;
   logic             start_q;
   logic             hit_p;
   logic             pause_p;
   logic             start_p;
   logic             win;
   logic             lose_life;
   logic             advance;
   logic [CNT_W-1:0] resume_cnt;
   logic             sprite_d;
   logic             map_d;
   logic             display_d;
   logic             ghost_d;

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < NUM_GHOSTS; i++) begin
         if (ghost_x[i*X_W +: X_W] == pacman_x && ghost_y[i*Y_W +: Y_W] == pacman_y)
            hit = 1'b1;
      end
   end

   // Edge registers track every cycle, in every state, so no stale edge survives a pause or respawn.
   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         hit_q   <= 1'b0;
         pause_q <= 1'b0;
         start_q <= 1'b0;
      end else begin
         hit_q   <= hit;
         pause_q <= pause;
         start_q <= start;
      end
   end

   assign hit_p   = hit & ~hit_q;
   assign pause_p = pause & ~pause_q;
   assign start_p = start & ~start_q;
   assign win     = (pill_count >= PILL_TARGET);

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n)
         cur_state <= ST_INIT;
      else
         cur_state <= nxt_state;
   end

   // A level clear outranks a same-cycle collision, so the win never costs a life.
   always_comb begin
      nxt_state = cur_state;
      lose_life = 1'b0;
      advance   = 1'b0;
      case (cur_state)
         ST_INIT:   if (start) nxt_state = ST_PLAY;
         ST_PLAY: begin
            if (win)
               nxt_state = ST_CLEAR;
            else if (hit_p) begin
               lose_life = 1'b1;
               nxt_state = (lives > 3'd1) ? ST_RESUME : ST_OVER;
            end else if (pause_p)
               nxt_state = ST_PAUSE;
         end
         ST_PAUSE:  if (pause_p) nxt_state = ST_PLAY;
         ST_RESUME: if (resume_cnt == '0) nxt_state = ST_PLAY;
         ST_CLEAR: begin
            if (start_p && level != LAST_LEVEL) begin
               advance   = 1'b1;
               nxt_state = ST_RESUME;
            end
         end
         ST_OVER:   nxt_state = ST_OVER;
         default:   nxt_state = ST_INIT;
      endcase
   end

   // Decoding the next state lets the registered outputs line up with the state register.
   always_comb begin
      sprite_d  = 1'b0;
      map_d     = 1'b0;
      display_d = 1'b0;
      ghost_d   = 1'b0;
      case (nxt_state)
         ST_INIT: begin
            sprite_d  = 1'b1;
            map_d     = 1'b1;
            display_d = 1'b1;
         end
         ST_PLAY:   ghost_d = 1'b1;
         ST_RESUME: begin
            sprite_d = 1'b1;
            map_d    = advance;
         end
         ST_CLEAR:  sprite_d = 1'b1;
         ST_OVER:   map_d = 1'b1;
         default:   ;
      endcase
   end

   always_ff @(posedge CLOCK_50) begin
      if (!reset_n) begin
         lives         <= INIT_LIVES;
         level         <= '0;
         resume_cnt    <= '0;
         life_lost     <= 1'b0;
         sprite_reset  <= 1'b1;
         map_wr_reset  <= 1'b1;
         display_reset <= 1'b1;
         ghost_enable  <= 1'b0;
      end else begin
         if (lose_life)
            lives <= (lives > 3'd1) ? lives - 3'd1 : 3'd0;
         if (advance)
            level <= level + LEVEL_W'(1);
         if (nxt_state == ST_RESUME && cur_state != ST_RESUME)
            resume_cnt <= RESUME_LOAD;
         else if (cur_state == ST_RESUME && resume_cnt != '0)
            resume_cnt <= resume_cnt - CNT_W'(1);
         life_lost     <= lose_life;
         sprite_reset  <= sprite_d;
         map_wr_reset  <= map_d;
         display_reset <= display_d;
         ghost_enable  <= ghost_d;
      end
   end

   assign state = cur_state;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboard bench for game_state_ctrl: stimulus queues the expected state/lives/level
// snapshots, and a negedge monitor checks each one as the DUT changes state.
module tb_game_state_ctrl;

   localparam int NG = 3;
   localparam int XW = 6;
   localparam int YW = 5;
   localparam int PW = 9;
   localparam int RC = 4;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             start;
   logic             pause;
   logic [XW-1:0]    pacman_x;
   logic [YW-1:0]    pacman_y;
   logic [NG*XW-1:0] ghost_x;
   logic [NG*YW-1:0] ghost_y;
   logic [PW-1:0]    pill_count;
   logic [2:0]       state;
   logic [2:0]       lives;
   logic             level;
   logic             sprite_reset;
   logic             map_wr_reset;
   logic             display_reset;
   logic             ghost_enable;
   logic             life_lost;

   always #5 clk = ~clk;

   game_state_ctrl #(
      .NUM_GHOSTS(NG), .X_W(XW), .Y_W(YW), .START_LIVES(3), .RESUME_CYCLES(RC),
      .PILL_W(PW), .TOTAL_PILLS(5), .MAX_LEVEL(2)
   ) dut (
      .CLOCK_50(clk), .reset_n(reset_n), .start(start), .pause(pause),
      .pacman_x(pacman_x), .pacman_y(pacman_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
      .pill_count(pill_count), .state(state), .lives(lives), .level(level),
      .sprite_reset(sprite_reset), .map_wr_reset(map_wr_reset),
      .display_reset(display_reset), .ghost_enable(ghost_enable), .life_lost(life_lost)
   );

   typedef struct {
      int st;
      int lv;
      int lvl;
      int ll;
      int mp;
   } exp_t;

   exp_t       exp_q[$];
   exp_t       mon_e;
   int         checks = 0;
   int         passes = 0;
   bit         armed = 1'b0;
   logic [2:0] prev_st = 3'd7;
   logic [2:0] prev_lives = 3'd7;
   logic       prev_lvl = 1'b0;
   int         prev_exp_st = 7;
   int         ll_cnt = 0;
   int         map_cnt = 0;
   int         res_len = 0;

   task automatic checkOutput(input string name, input int act, input int req);
      checks++;
      if (act == req)
         passes++;
      else
         $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
   endtask

   task automatic expectEvent(input int st, input int lv, input int lvl, input int ll, input int mp);
      exp_t e;
      e.st = st; e.lv = lv; e.lvl = lvl; e.ll = ll; e.mp = mp;
      exp_q.push_back(e);
   endtask

   task automatic applyStimulus(input logic s, input logic p, input logic [PW-1:0] pills, input int overlap);
      logic [NG*XW-1:0] gx;
      logic [NG*YW-1:0] gy;
      gx = {6'd3, 6'd2, 6'd1};
      gy = {5'd3, 5'd2, 5'd1};
      if (overlap >= 0) begin
         gx[overlap*XW +: XW] = 6'd10;
         gy[overlap*YW +: YW] = 5'd10;
      end
      start      = s;
      pause      = p;
      pill_count = pills;
      ghost_x    = gx;
      ghost_y    = gy;
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Every change of state/lives/level is an event that must match the head of the queue.
   always @(negedge clk) begin
      if (armed) begin
         if (life_lost) ll_cnt++;
         if (map_wr_reset && state == 3'd3) map_cnt++;
         if (state != prev_st || lives != prev_lives || level != prev_lvl) begin
            if (prev_st == 3'd3 && state == 3'd1)
               checkOutput("resume_len", res_len, RC);
            if (exp_q.size() == 0)
               checkOutput("unexpected_event_state", int'(state), 7);
            else begin
               logic [3:0] dec_exp;
               mon_e = exp_q.pop_front();
               dec_exp = {(mon_e.st == 0 || mon_e.st == 3 || mon_e.st == 4),
                          (mon_e.st == 0 || mon_e.st == 5 || (mon_e.st == 3 && prev_exp_st == 4)),
                          (mon_e.st == 0),
                          (mon_e.st == 1)};
               checkOutput("state", int'(state), mon_e.st);
               checkOutput("lives", int'(lives), mon_e.lv);
               checkOutput("level", int'(level), mon_e.lvl);
               checkOutput("life_lost_pulses", ll_cnt, mon_e.ll);
               checkOutput("map_wr_pulses", map_cnt, mon_e.mp);
               checkOutput("decode_spr_map_disp_ghost",
                           int'({sprite_reset, map_wr_reset, display_reset, ghost_enable}),
                           int'(dec_exp));
               prev_exp_st = mon_e.st;
            end
            res_len    = (state == 3'd3) ? 1 : 0;
            prev_st    = state;
            prev_lives = lives;
            prev_lvl   = level;
         end else if (state == 3'd3) begin
            res_len++;
         end
      end
   end

   initial begin
      pacman_x = 6'd10;
      pacman_y = 5'd10;
      reset_n  = 1'b0;
      applyStimulus(1'b0, 1'b0, 9'd0, -1);
      cyc(3);
      expectEvent(0, 3, 0, 0, 0);
      armed = 1'b1;
      cyc(2);
      reset_n = 1'b1;
      cyc(2);

      // start from INIT
      expectEvent(1, 3, 0, 0, 0);
      applyStimulus(1'b1, 1'b0, 9'd0, -1); cyc(1);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(3);

      // sustained overlap on ghost 2 costs one life
      expectEvent(3, 2, 0, 1, 0);
      expectEvent(1, 2, 0, 1, 0);
      applyStimulus(1'b0, 1'b0, 9'd0, 2); cyc(10);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(3);

      // two more overlaps: down to game over
      expectEvent(3, 1, 0, 2, 0);
      expectEvent(1, 1, 0, 2, 0);
      applyStimulus(1'b0, 1'b0, 9'd0, 2); cyc(2);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(8);
      expectEvent(5, 0, 0, 3, 0);
      applyStimulus(1'b0, 1'b0, 9'd0, 2); cyc(2);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(2);
      applyStimulus(1'b1, 1'b0, 9'd0, -1); cyc(1);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(4);

      // reset out of OVER, then start
      expectEvent(0, 3, 0, 3, 0);
      reset_n = 1'b0; cyc(1); reset_n = 1'b1; cyc(2);
      expectEvent(1, 3, 0, 3, 0);
      applyStimulus(1'b1, 1'b0, 9'd0, -1); cyc(1);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(3);

      // win and hit together resolve as a win; advance to level 1
      expectEvent(4, 3, 0, 3, 0);
      applyStimulus(1'b0, 1'b0, 9'd5, 1); cyc(2);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(2);
      expectEvent(3, 3, 1, 3, 1);
      expectEvent(1, 3, 1, 3, 1);
      applyStimulus(1'b1, 1'b0, 9'd0, -1); cyc(1);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(8);

      // clear on the last level: start keeps CLEAR, level does not wrap
      expectEvent(4, 3, 1, 3, 1);
      applyStimulus(1'b0, 1'b0, 9'd5, -1); cyc(2);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(2);
      applyStimulus(1'b1, 1'b0, 9'd0, -1); cyc(1);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(6);
      expectEvent(0, 3, 0, 3, 1);
      reset_n = 1'b0; cyc(1); reset_n = 1'b1; cyc(2);
      expectEvent(1, 3, 0, 3, 1);
      applyStimulus(1'b1, 1'b0, 9'd0, -1); cyc(1);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(3);

      // pause ignores hits; leaving pause with overlap present loses nothing
      expectEvent(2, 3, 0, 3, 1);
      applyStimulus(1'b0, 1'b1, 9'd0, -1); cyc(1);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(2);
      applyStimulus(1'b0, 1'b0, 9'd0, 0); cyc(3);
      expectEvent(1, 3, 0, 3, 1);
      applyStimulus(1'b0, 1'b1, 9'd0, 0); cyc(1);
      applyStimulus(1'b0, 1'b0, 9'd0, 0); cyc(4);
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(3);

      // reset in the middle of a respawn countdown
      expectEvent(3, 2, 0, 4, 1);
      expectEvent(0, 3, 0, 4, 1);
      applyStimulus(1'b0, 1'b0, 9'd0, 0); cyc(2);
      reset_n = 1'b0; cyc(1); reset_n = 1'b1;
      applyStimulus(1'b0, 1'b0, 9'd0, -1); cyc(6);

      checkOutput("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
